// File: rtl/lighting_pkg.sv
// Shared definitions for the lighting front end and colour sequencer:
// auto-repeat phase type, default timing constants and colour codes.
package lighting_pkg;

  // Auto-repeat phase: waiting for the first repeat, then periodic repeats
  typedef enum logic {
    RPT_DELAY  = 1'b0,
    RPT_PERIOD = 1'b1
  } rpt_phase_t;

  // Default timing (clock cycles)
  localparam int unsigned DEF_CNT_W           = 32'd16;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000;
  localparam int unsigned DEF_REPEAT_DELAY    = 32'd50000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 32'd20000;

  // Colour codes shared with the sequencer ({r,g,b} lamp enables)
  localparam logic [2:0] COLOUR_OFF   = 3'b000;
  localparam logic [2:0] COLOUR_RED   = 3'b100;
  localparam logic [2:0] COLOUR_GREEN = 3'b010;
  localparam logic [2:0] COLOUR_BLUE  = 3'b001;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-high reset.
// A value sampled on edge E0 is visible on q after edge E1.
module sync_2ff #(
  parameter int unsigned WIDTH = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;

  // Two-stage metastability filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner feeding the lighting sequencer's button input.
// Synchronises a raw bouncy button, debounces it into `pressed`, and emits
// a one-cycle `step` pulse per debounced press.
// Optional build macro BUTTON_CONDITIONER_AUTO_REPEAT_EN adds auto-repeat
// pulses while the button stays pressed.
module button_conditioner
  import lighting_pkg::*;
#(
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pressed,
  output logic step
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             btn_sync_s;
  logic [CNT_W-1:0] deb_cnt_r;
  logic [CNT_W-1:0] deb_cnt_nxt_s;
  logic             pressed_r;
  logic             pressed_nxt_s;
  logic             step_r;
  logic             step_nxt_s;
  logic             rise_s;
  logic             rpt_fire_s;

  sync_2ff #(
    .WIDTH(32'd1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_sync_s)
  );

  // Debounce: pressed follows the synchronised input only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    deb_cnt_nxt_s = deb_cnt_r;
    pressed_nxt_s = pressed_r;
    if (btn_sync_s == pressed_r) begin
      deb_cnt_nxt_s = '0;
    end else if (deb_cnt_r == DEB_LAST) begin
      pressed_nxt_s = btn_sync_s;
      deb_cnt_nxt_s = '0;
    end else begin
      deb_cnt_nxt_s = deb_cnt_r + CNT_ONE;
    end
  end

  assign rise_s = pressed_nxt_s & ~pressed_r;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);

  rpt_phase_t       rpt_phase_r;
  rpt_phase_t       rpt_phase_nxt_s;
  logic [CNT_W-1:0] rpt_cnt_r;
  logic [CNT_W-1:0] rpt_cnt_nxt_s;

  // Repeat timer: restarts on the press pulse and is held clear whenever
  // the debounced level is (or is about to become) low, so a release edge
  // can never coincide with a repeat pulse
  always_comb begin
    rpt_cnt_nxt_s   = rpt_cnt_r;
    rpt_phase_nxt_s = rpt_phase_r;
    rpt_fire_s      = 1'b0;
    if (!pressed_nxt_s || rise_s) begin
      rpt_cnt_nxt_s   = '0;
      rpt_phase_nxt_s = RPT_DELAY;
    end else begin
      case (rpt_phase_r)
        RPT_DELAY: begin
          if (rpt_cnt_r == RPT_DELAY_LAST) begin
            rpt_fire_s      = 1'b1;
            rpt_cnt_nxt_s   = '0;
            rpt_phase_nxt_s = RPT_PERIOD;
          end else begin
            rpt_cnt_nxt_s = rpt_cnt_r + CNT_ONE;
          end
        end
        RPT_PERIOD: begin
          if (rpt_cnt_r == RPT_PERIOD_LAST) begin
            rpt_fire_s    = 1'b1;
            rpt_cnt_nxt_s = '0;
          end else begin
            rpt_cnt_nxt_s = rpt_cnt_r + CNT_ONE;
          end
        end
        default: begin
          rpt_cnt_nxt_s   = '0;
          rpt_phase_nxt_s = RPT_DELAY;
        end
      endcase
    end
  end

  // Repeat timer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_r   <= '0;
      rpt_phase_r <= RPT_DELAY;
    end else begin
      rpt_cnt_r   <= rpt_cnt_nxt_s;
      rpt_phase_r <= rpt_phase_nxt_s;
    end
  end
`else
  assign rpt_fire_s = 1'b0;

  // Repeat timing has no effect in this build; the parameters stay in the
  // interface so both builds share one parameter list
  if (REPEAT_DELAY == 32'd0 || REPEAT_PERIOD == 32'd0) begin : g_repeat_unused
  end
`endif

  // A pulse directly after a pulse is dropped so step is never high on two
  // consecutive cycles, even for degenerate one-cycle repeat timing
  assign step_nxt_s = (rise_s | rpt_fire_s) & ~step_r;

  // Debounce counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_r <= '0;
      pressed_r <= 1'b0;
      step_r    <= 1'b0;
    end else begin
      deb_cnt_r <= deb_cnt_nxt_s;
      pressed_r <= pressed_nxt_s;
      step_r    <= step_nxt_s;
    end
  end

  assign pressed = pressed_r;
  assign step    = step_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (works with and without
// BUTTON_CONDITIONER_AUTO_REPEAT_EN defined).
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk;
  logic rst;
  logic btn_in;
  logic pressed;
  logic step;

  button_conditioner #(
    .CNT_W           (8),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .pressed (pressed),
    .step    (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: history of btn samples (two leading zeros stand
  // for the cleared synchroniser), debounced level, cycles since press pulse
  bit hist[$];
  bit m_pressed;
  bit m_step;
  int since;

  int idx;
  int pulses[$];
  bit plev[256];

  typedef struct {
    bit btn;
    bit exp_p;
    bit exp_s;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s idx=%0d actual=%0b required=%0b", name, idx, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    m_pressed = 1'b0;
    m_step    = 1'b0;
    since     = 0;
  endtask

  // Level flips once the last D synchronised samples all disagree with it;
  // synchronised value seen at an edge is the btn sample from two edges back
  task automatic model_edge(input bit b);
    bit all_diff;
    bit new_p;
    hist.push_back(b);
    all_diff = 1'b1;
    if (hist.size() < D + 2) all_diff = 1'b0;
    else begin
      for (int i = 0; i < D; i++)
        if (hist[hist.size() - 3 - i] == m_pressed) all_diff = 1'b0;
    end
    new_p  = all_diff ? !m_pressed : m_pressed;
    m_step = 1'b0;
    if (new_p && !m_pressed) begin
      m_step = 1'b1;
      since  = 0;
    end else if (new_p) begin
      since++;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      if (since == RD || (since > RD && ((since - RD) % RP) == 0)) m_step = 1'b1;
`endif
    end else begin
      since = 0;
    end
    m_pressed = new_p;
    if (hist.size() > 64) void'(hist.pop_front());
  endtask

  task automatic tick(input bit b);
    btn_in = b;
    @(posedge clk);
    #1;
    model_edge(b);
    chk("pressed_vs_model", pressed, m_pressed);
    chk("step_vs_model", step, m_step);
    if (step === 1'b1) pulses.push_back(idx);
    if (idx < 256) plev[idx] = pressed;
    idx++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    chk("rst_async_pressed", pressed, 1'b0);
    chk("rst_async_step", step, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    chk("rst_hold_pressed", pressed, 1'b0);
    chk("rst_hold_step", step, 1'b0);
    model_reset();
    rst = 1'b0;
    idx = 0;
    pulses.delete();
  endtask

  task automatic chk_pulses(input string name, input int exp[$]);
    chk_int({name, "_count"}, pulses.size(), exp.size());
    for (int i = 0; i < exp.size() && i < pulses.size(); i++)
      chk_int({name, "_at"}, pulses[i], exp[i]);
  endtask

  initial begin
    int exp_q[$];
    int run_len;
    bit run_val;

    rst    = 1'b1;
    btn_in = 1'b0;
    model_reset();

    // Clean press: two idle cycles, then held high; pulse 5 edges after
    // the first high sample
    for (int i = 0; i < 14; i++) begin
      tbl[i].btn   = (i >= 2);
      tbl[i].exp_p = (i >= 7);
      tbl[i].exp_s = (i == 7);
    end
    do_reset(2);
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].btn);
      chk("tbl_pressed", pressed, tbl[i].exp_p);
      chk("tbl_step", step, tbl[i].exp_s);
    end

    // Glitch: 3 high cycles are too short
    do_reset(2);
    for (int i = 0; i < 15; i++) tick(i < 3);
    chk_int("glitch_pulses", pulses.size(), 0);
    chk("glitch_pressed", pressed, 1'b0);

    // Bounce 1,0,1,0,1 every 2 cycles then stable: final rise at idx 8
    do_reset(2);
    for (int i = 0; i < 20; i++) tick(((i / 2) % 2) == 0 || i >= 8);
    exp_q = {13};
    chk_pulses("bounce", exp_q);

    // Release and re-press
    do_reset(2);
    for (int i = 0; i < 40; i++) tick(((i / 10) % 2) == 0);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    exp_q = {5, 13, 25, 33};
`else
    exp_q = {5, 25};
`endif
    chk_pulses("repress", exp_q);
    chk("release_hold", plev[14], 1'b1);
    chk("release_fall", plev[15], 1'b0);
    chk("repress_fall", plev[35], 1'b0);

    // Reset mid-count with the button held throughout
    do_reset(2);
    for (int i = 0; i < 3; i++) tick(1'b1);
    do_reset(2);
    for (int i = 0; i < 10; i++) tick(1'b1);
    exp_q = {5};
    chk_pulses("rst_mid", exp_q);

    // Long hold then release: repeat pulses only in the auto-repeat build
    do_reset(2);
    for (int i = 0; i < 42; i++) tick(i < 30);
    exp_q = {5};
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    for (int t = 5 + RD; t < 35; t += RP) exp_q.push_back(t);
`endif
    chk_pulses("hold", exp_q);
    for (int i = 1; i < pulses.size(); i++)
      chk_int("hold_gap", pulses[i] - pulses[i-1], (i == 1) ? RD : RP);

    // Randomised runs of random length
    do_reset(2);
    run_val = 1'b0;
    for (int r = 0; r < 300; r++) begin
      run_len = $urandom_range(1, 14);
      run_val = ~run_val;
      for (int k = 0; k < run_len; k++) tick(run_val);
      if (($urandom % 40) == 0) do_reset($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
